// File: rtl/keyin_pkg.sv
// rtl/keyin_pkg.sv - shared types and helpers for the keypad/enter input block
package keyin_pkg;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } key_t;

   localparam key_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

   typedef enum logic {
      HS_EMPTY = 1'b0,
      HS_FULL  = 1'b1
   } hs_state_t;

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Closure count saturates at 2: anything beyond one closure is already ambiguous.
   function automatic logic [1:0] pop_sat(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'd0, v[i]};
      end
      return (n >= 3'd2) ? 2'd2 : n[1:0];
   endfunction

endpackage

// File: rtl/keyin_debounce.sv
// rtl/keyin_debounce.sv - frame-rate debouncer; flags accepted transitions out of the idle (zero) value
module keydebounce #(
   parameter int WIDTH    = 5,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] accepted,
   output logic             rise
);

   localparam logic [3:0] LIMIT = 4'(DEBOUNCE);

   logic [WIDTH-1:0] cand;
   logic [3:0]       cnt;
   logic [3:0]       cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (din != cand)
         cnt_next = 4'd1;
      else if (cnt != LIMIT)
         cnt_next = cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand     <= '0;
         cnt      <= 4'd0;
         accepted <= '0;
         rise     <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (sample) begin
            cand <= din;
            cnt  <= cnt_next;
            if (cnt_next == LIMIT && din != accepted) begin
               accepted <= din;
               rise     <= (accepted == '0) && (din != '0);
            end
         end
      end
   end

endmodule

// File: rtl/keyin.sv
// rtl/keyin.sv - 4x4 keypad scanner with digit shift register and enter/ack handshake to the CPU
module keyin
   import keyin_pkg::*;
#(
   parameter int SCAN_DIV = 1024,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col_in,
   input  logic        enter_in,
   input  logic        in_ack,
   output logic [3:0]  row_out,
   output logic [15:0] digits_out,
   output logic [15:0] in_dat,
   output logic        in_valid,
   output logic        overrun
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [3:0]       col_s1, col_s2;
   logic             ent_s1, ent_s2;
   logic [DIV_W-1:0] div;
   logic             tc;
   logic             frame_end;
   logic [1:0]       acc_cnt;
   logic [3:0]       acc_code;
   logic [1:0]       cur_cnt;
   logic [3:0]       cur_code;
   logic [2:0]       sum_cnt;
   logic [1:0]       tot_cnt;
   logic [3:0]       tot_code;
   key_t             frame_res;
   key_t             key_acc;
   logic             key_rise;
   logic [0:0]       ent_acc;
   logic             ent_rise;
   logic             digit_ev;
   logic             enter_ev;
   logic [15:0]      digits_next;
   hs_state_t        state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_s1 <= 4'd0;
         col_s2 <= 4'd0;
         ent_s1 <= 1'b0;
         ent_s2 <= 1'b0;
      end else begin
         col_s1 <= col_in;
         col_s2 <= col_s1;
         ent_s1 <= enter_in;
         ent_s2 <= ent_s1;
      end
   end

   assign tc        = (div == DIV_W'(SCAN_DIV - 1));
   assign frame_end = tc && row_out[3];

   // Frame result folds the current slot's sample in, so frame_end sees all four rows.
   always_comb begin
      cur_cnt  = pop_sat(col_s2);
      cur_code = {onehot_idx(row_out), onehot_idx(col_s2)};
      sum_cnt  = {1'b0, acc_cnt} + {1'b0, cur_cnt};
      tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
      tot_code = (acc_cnt != 2'd0) ? acc_code : cur_code;
      frame_res = KEY_NONE;
      if (tot_cnt == 2'd1)
         frame_res = '{valid: 1'b1, code: tot_code};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div      <= '0;
         row_out  <= 4'b0001;
         acc_cnt  <= 2'd0;
         acc_code <= 4'd0;
      end else begin
         div <= div + 1'b1;
         if (tc) begin
            row_out <= {row_out[2:0], row_out[3]};
            if (frame_end) begin
               acc_cnt  <= 2'd0;
               acc_code <= 4'd0;
            end else begin
               acc_cnt  <= tot_cnt;
               acc_code <= tot_code;
            end
         end
      end
   end

   keydebounce #(.WIDTH(5), .DEBOUNCE(DEBOUNCE)) u_key_db (
      .clk      (clk),
      .reset    (reset),
      .sample   (frame_end),
      .din      (frame_res),
      .accepted (key_acc),
      .rise     (key_rise)
   );

   keydebounce #(.WIDTH(1), .DEBOUNCE(DEBOUNCE)) u_ent_db (
      .clk      (clk),
      .reset    (reset),
      .sample   (frame_end),
      .din      (ent_s2),
      .accepted (ent_acc),
      .rise     (ent_rise)
   );

   assign digit_ev    = key_rise && key_acc.valid;
   assign enter_ev    = ent_rise && ent_acc[0];
   // Digit shifts in ahead of a same-frame enter so the enter captures it.
   assign digits_next = digit_ev ? {digits_out[11:0], key_acc.code} : digits_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HS_EMPTY;
         digits_out <= 16'd0;
         in_dat     <= 16'd0;
         in_valid   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state)
            HS_EMPTY: begin
               if (enter_ev) begin
                  in_dat     <= digits_next;
                  digits_out <= 16'd0;
                  in_valid   <= 1'b1;
                  state      <= HS_FULL;
               end else begin
                  digits_out <= digits_next;
               end
            end
            HS_FULL: begin
               if (enter_ev && in_ack) begin
                  in_dat     <= digits_next;
                  digits_out <= 16'd0;
                  overrun    <= 1'b0;
               end else if (enter_ev) begin
                  overrun    <= 1'b1;
                  digits_out <= digits_next;
               end else begin
                  digits_out <= digits_next;
                  if (in_ack) begin
                     in_valid <= 1'b0;
                     overrun  <= 1'b0;
                     state    <= HS_EMPTY;
                  end
               end
            end
            default: state <= HS_EMPTY;
         endcase
      end
   end

endmodule
